// File: rtl/timer_pkg.sv
// Shared types and default sizing for the countdown timer family.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_TICK_DIV = 50000000;

endpackage

// File: rtl/sub_by_1.sv
// Combinational WIDTH-bit decrementer, the mirror of add_by_1.
module sub_by_1 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] dec_c
);

    assign dec_c = a - WIDTH'(1);

endmodule

// File: rtl/down_cnt_timer.sv
// Loadable countdown timer with prescaled clock-enable tick, pause/resume and auto-reload.
module down_cnt_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nx;
    logic [WIDTH-1:0] counter_nx;
    logic [WIDTH-1:0] dec_c;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nx;
    logic             done_nx;
    logic             tick_c;

    sub_by_1 #(.WIDTH(WIDTH)) u_dec (
        .a     (counter),
        .dec_c (dec_c)
    );

    assign tick_c = (presc == PRESC_MAX);

    // Next-state and datapath: load > stop > start > tick.
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        reload_nx  = reload_reg;
        presc_nx   = presc;
        done_nx    = 1'b0;

        if (load) begin
            counter_nx = load_val;
            reload_nx  = load_val;
            presc_nx   = '0;
            state_nx   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (counter != '0) begin
                            state_nx = RUN;
                            presc_nx = '0;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nx = PAUSE;
                    end else if (tick_c) begin
                        presc_nx = '0;
                        if (counter == WIDTH'(1)) begin
                            done_nx = 1'b1;
                            if (auto_reload) begin
                                counter_nx = reload_reg;
                            end else begin
                                counter_nx = '0;
                                state_nx   = IDLE;
                            end
                        end else begin
                            counter_nx = dec_c;
                        end
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= '0;
            reload_reg <= '0;
            presc      <= '0;
            busy       <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            counter    <= counter_nx;
            reload_reg <= reload_nx;
            presc      <= presc_nx;
            busy       <= (state_nx == RUN);
            paused     <= (state_nx == PAUSE);
            done       <= done_nx;
        end
    end

endmodule
